// File: rtl/pid_pkg.sv
// Shared types, widths and helpers for the time-multiplexed PID engine.
package pid_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PROD_W = 33;
  localparam int unsigned ACC_W  = 35;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    MAC_P,
    MAC_I,
    MAC_D,
    OUT
  } pid_state_e;

  localparam logic [1:0] CFG_KP = 2'd0;
  localparam logic [1:0] CFG_KI = 2'd1;
  localparam logic [1:0] CFG_KD = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 35'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -35'sd32768;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return 16'sh7FFF;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pid_shared_mac.sv
// Single shared signed multiplier feeding a registered accumulator.
module pid_shared_mac
  import pid_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [DATA_W-1:0]        gain,
  input  logic signed [DATA_W-1:0] term,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  always_comb begin
    // Gain is unsigned, so it enters the multiplier zero-extended to 17 bits.
    prod     = $signed({1'b0, gain}) * term;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_d    = acc_q;
    if (en) begin
      acc_d = clr ? prod_ext : acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/pid_mac_sequencer.sv
// PID controller: error/integral/derivative formation, then P, I, D terms
// scheduled over one shared multiplier, producing a saturated motor power word.
module pid_mac_sequencer
  import pid_pkg::*;
#(
  parameter logic [15:0] TARGET_ANGLE = 16'd180,
  parameter logic [15:0] KP_RST       = 16'd77,
  parameter logic [15:0] KI_RST       = 16'd1,
  parameter logic [15:0] KD_RST       = 16'd10,
  parameter logic [15:0] INTEG_LIM    = 16'd1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [DATA_W-1:0]        angle,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_sel,
  input  logic [DATA_W-1:0]        cfg_data,
  input  logic                     clear_integ,
  output logic signed [DATA_W-1:0] motor_power,
  output logic                     power_valid,
  output logic                     busy,
  output logic [7:0]               overrun_cnt
);

  localparam logic signed [16:0] LIM_POS = {1'b0, INTEG_LIM};
  localparam logic signed [16:0] LIM_NEG = -LIM_POS;

  pid_state_e               state_q, state_d;
  logic [DATA_W-1:0]        angle_q, angle_d;
  logic [DATA_W-1:0]        prev_angle_q, prev_angle_d;
  logic signed [DATA_W-1:0] err_q, err_d;
  logic signed [DATA_W-1:0] dlt_q, dlt_d;
  logic signed [DATA_W-1:0] integ_q, integ_d;
  logic [DATA_W-1:0]        kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic [DATA_W-1:0]        kp_sh_q, kp_sh_d, ki_sh_q, ki_sh_d, kd_sh_q, kd_sh_d;
  logic                     pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0]        pend_angle_q, pend_angle_d;
  logic                     clr_pend_q, clr_pend_d;
  logic [7:0]               overrun_q, overrun_d;
  logic signed [DATA_W-1:0] motor_power_q, motor_power_d;
  logic                     power_valid_q, power_valid_d;
  logic                     busy_q, busy_d;

  logic signed [DATA_W-1:0] err_c;
  logic signed [16:0]       integ_sum;
  logic                     mac_en, mac_clr;
  logic [DATA_W-1:0]        mac_gain;
  logic signed [DATA_W-1:0] mac_term;
  logic signed [ACC_W-1:0]  mac_acc;

  pid_shared_mac u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (mac_en),
    .clr  (mac_clr),
    .gain (mac_gain),
    .term (mac_term),
    .acc  (mac_acc)
  );

  always_comb begin
    mac_en   = 1'b0;
    mac_clr  = 1'b0;
    mac_gain = '0;
    mac_term = '0;
    case (state_q)
      MAC_P: begin
        mac_en   = 1'b1;
        mac_clr  = 1'b1;
        mac_gain = kp_q;
        mac_term = err_q;
      end
      MAC_I: begin
        mac_en   = 1'b1;
        mac_gain = ki_q;
        mac_term = integ_q;
      end
      MAC_D: begin
        mac_en   = 1'b1;
        mac_gain = kd_q;
        mac_term = dlt_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    angle_d       = angle_q;
    prev_angle_d  = prev_angle_q;
    err_d         = err_q;
    dlt_d         = dlt_q;
    integ_d       = integ_q;
    kp_d          = kp_q;
    ki_d          = ki_q;
    kd_d          = kd_q;
    kp_sh_d       = kp_sh_q;
    ki_sh_d       = ki_sh_q;
    kd_sh_d       = kd_sh_q;
    pend_valid_d  = pend_valid_q;
    pend_angle_d  = pend_angle_q;
    clr_pend_d    = clr_pend_q;
    overrun_d     = overrun_q;
    motor_power_d = motor_power_q;
    power_valid_d = 1'b0;

    err_c     = angle_q - TARGET_ANGLE;
    integ_sum = {integ_q[DATA_W-1], integ_q} + {err_c[DATA_W-1], err_c};

    if (cfg_we) begin
      case (cfg_sel)
        CFG_KP:  kp_sh_d = cfg_data;
        CFG_KI:  ki_sh_d = cfg_data;
        CFG_KD:  kd_sh_d = cfg_data;
        default: ;
      endcase
    end

    if (sample_valid && state_q != IDLE) begin
      pend_angle_d = angle;
      pend_valid_d = 1'b1;
      if (pend_valid_q && overrun_q != 8'hFF) begin
        overrun_d = overrun_q + 8'd1;
      end
    end

    // A clear seen mid-computation is deferred to OUT so the in-flight result keeps its integral.
    if (clear_integ && state_q != IDLE) begin
      clr_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (clear_integ) begin
          integ_d = '0;
        end
        if (sample_valid || pend_valid_q) begin
          angle_d = sample_valid ? angle : pend_angle_q;
          if (!sample_valid) begin
            pend_valid_d = 1'b0;
          end
          kp_d    = kp_sh_q;
          ki_d    = ki_sh_q;
          kd_d    = kd_sh_q;
          state_d = ERR;
        end
      end
      ERR: begin
        err_d        = err_c;
        dlt_d        = angle_q - prev_angle_q;
        prev_angle_d = angle_q;
        if (integ_sum > LIM_POS) begin
          integ_d = LIM_POS[DATA_W-1:0];
        end else if (integ_sum < LIM_NEG) begin
          integ_d = LIM_NEG[DATA_W-1:0];
        end else begin
          integ_d = integ_sum[DATA_W-1:0];
        end
        state_d = MAC_P;
      end
      MAC_P: state_d = MAC_I;
      MAC_I: state_d = MAC_D;
      MAC_D: state_d = OUT;
      OUT: begin
        motor_power_d = sat16(mac_acc);
        power_valid_d = 1'b1;
        if (clr_pend_q || clear_integ) begin
          integ_d = '0;
        end
        clr_pend_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      angle_q       <= '0;
      prev_angle_q  <= TARGET_ANGLE;
      err_q         <= '0;
      dlt_q         <= '0;
      integ_q       <= '0;
      kp_q          <= KP_RST;
      ki_q          <= KI_RST;
      kd_q          <= KD_RST;
      kp_sh_q       <= KP_RST;
      ki_sh_q       <= KI_RST;
      kd_sh_q       <= KD_RST;
      pend_valid_q  <= 1'b0;
      pend_angle_q  <= '0;
      clr_pend_q    <= 1'b0;
      overrun_q     <= '0;
      motor_power_q <= '0;
      power_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      angle_q       <= angle_d;
      prev_angle_q  <= prev_angle_d;
      err_q         <= err_d;
      dlt_q         <= dlt_d;
      integ_q       <= integ_d;
      kp_q          <= kp_d;
      ki_q          <= ki_d;
      kd_q          <= kd_d;
      kp_sh_q       <= kp_sh_d;
      ki_sh_q       <= ki_sh_d;
      kd_sh_q       <= kd_sh_d;
      pend_valid_q  <= pend_valid_d;
      pend_angle_q  <= pend_angle_d;
      clr_pend_q    <= clr_pend_d;
      overrun_q     <= overrun_d;
      motor_power_q <= motor_power_d;
      power_valid_q <= power_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign motor_power = motor_power_q;
  assign power_valid = power_valid_q;
  assign busy        = busy_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_pid_mac_sequencer.sv
// Directed bench for pid_mac_sequencer with hand-computed expected outputs.
module tb_pid_mac_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_valid;
  logic [15:0]        angle;
  logic               cfg_we;
  logic [1:0]         cfg_sel;
  logic [15:0]        cfg_data;
  logic               clear_integ;
  logic signed [15:0] motor_power;
  logic               power_valid;
  logic               busy;
  logic [7:0]         overrun_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pid_mac_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .angle        (angle),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .clear_integ  (clear_integ),
    .motor_power  (motor_power),
    .power_valid  (power_valid),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b0; angle = '0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; clear_integ = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [15:0] val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = val;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Waits (bounded) for the power_valid strobe; n = edges counted.
  task automatic wait_pv(input int unsigned limit, output int unsigned n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!power_valid && n < limit);
  endtask

  task automatic send(input logic [15:0] a, input longint exp_pw, input string tag);
    int unsigned n = 0;
    int unsigned busy_n = 0;
    @(negedge clk);
    sample_valid = 1'b1; angle = a;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    while (!power_valid && n < 12) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 5);
    chk({tag, "_busy"}, busy_n, 5);
    chk({tag, "_pw"}, motor_power, exp_pw);
  endtask

  initial begin
    int unsigned n;
    longint integ_exp[6] = '{179, 358, 537, 716, 895, 1023};

    do_reset();
    #1;
    chk("rst_pw", motor_power, 0);
    chk("rst_pv", power_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun_cnt, 0);

    send(16'd190, 880, "a190");
    @(posedge clk); #1;
    chk("pv_pulse", power_valid, 0);
    chk("pw_hold", motor_power, 880);
    send(16'd200, 1670, "a200");

    do_reset();
    send(16'd0, -15840, "a0");

    do_reset();
    cfg_write(2'd0, 16'd0);
    cfg_write(2'd1, 16'd1);
    cfg_write(2'd2, 16'd0);
    cfg_write(2'd3, 16'd999);
    for (int i = 0; i < 6; i++) begin
      send(16'd359, integ_exp[i], $sformatf("int%0d", i));
    end
    @(negedge clk); clear_integ = 1'b1;
    @(negedge clk); clear_integ = 1'b0;
    send(16'd180, 0, "clr");

    do_reset();
    cfg_write(2'd0, 16'd1000);
    send(16'd359, 32767, "satp");
    send(16'd0, -32768, "satn");

    do_reset();
    @(negedge clk); sample_valid = 1'b1; angle = 16'd190;
    @(negedge clk); angle = 16'd195;
    @(negedge clk); angle = 16'd200;
    @(negedge clk); sample_valid = 1'b0;
    wait_pv(12, n);
    chk("ovr_lat1", n, 3);
    chk("ovr_pw1", motor_power, 880);
    chk("ovr_cnt", overrun_cnt, 1);
    wait_pv(12, n);
    chk("ovr_gap", n, 6);
    chk("ovr_pw2", motor_power, 1670);
    wait_pv(12, n);
    chk("ovr_nomore", power_valid, 0);

    do_reset();
    @(negedge clk); sample_valid = 1'b1; angle = 16'd190;
    @(negedge clk); sample_valid = 1'b0;
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 16'd100;
    @(negedge clk); cfg_we = 1'b0;
    wait_pv(12, n);
    chk("sh_lat", n, 4);
    chk("sh_old", motor_power, 880);
    send(16'd200, 2130, "sh_new");

    do_reset();
    @(negedge clk); sample_valid = 1'b1; angle = 16'd190;
    @(negedge clk); sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_pw", motor_power, 0);
    chk("mid_busy0", busy, 0);
    chk("mid_ovr", overrun_cnt, 0);
    wait_pv(8, n);
    chk("mid_nopv", power_valid, 0);
    send(16'd190, 880, "post");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pid_mac_sequencer.md
Name: pid_mac_sequencer

Overview:
Time-multiplexed PID engine for the balancing-robot control loop. Sits between the Arduino angle receiver and the motor PWM driver. On each accepted angle sample it forms error, clamped integral and derivative. It then schedules one shared 16x16 signed multiplier across the P, I and D terms and emits a saturated motor power word with a valid strobe. Gains are runtime-writable through a small config port with shadowing.

Parameters:
TARGET_ANGLE, 16'd180, setpoint angle, unsigned degrees
KP_RST, 16'd77, proportional gain after reset
KI_RST, 16'd1, integral gain after reset
KD_RST, 16'd10, derivative gain after reset
INTEG_LIM, 16'd1023, symmetric integral clamp magnitude

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
sample_valid  in  1  one-cycle strobe: angle is new
angle  in  16  unsigned angle, 0..359
cfg_we  in  1  gain write strobe
cfg_sel  in  2  0=KP, 1=KI, 2=KD, 3=ignored
cfg_data  in  16  unsigned gain value
clear_integ  in  1  zero the integral accumulator
motor_power  out  16  signed, saturated controller output
power_valid  out  1  one-cycle strobe: motor_power updated
busy  out  1  high in any state other than IDLE
overrun_cnt  out  8  saturating count of overwritten pending samples

Behaviour:
- Reset: motor_power=0, power_valid=0, busy=0, overrun_cnt=0, integ=0, prev_angle=TARGET_ANGLE, active gains and shadow gains = *_RST, pending slot empty, FSM=IDLE. Reset mid-computation aborts it with no power_valid.
- FSM states:
  - IDLE: on sample_valid, or when the pending slot is full, capture the angle and copy shadow gains to active gains, then go to ERR. A direct sample_valid has priority over the pending slot; the pending slot stays pending.
  - ERR: err = angle - TARGET_ANGLE (16b two's complement). d = angle - prev_angle. integ_next = clamp(integ + err, -INTEG_LIM, +INTEG_LIM), with the sum computed in 17b before clamping. prev_angle <= angle.
  - MAC_P: acc = KP*err.
  - MAC_I: acc += KI*integ.
  - MAC_D: acc += KD*d.
  - OUT: motor_power <= sat16(acc); power_valid=1 for exactly this cycle; go to IDLE.
- Arithmetic: gains are zero-extended to 17b signed. Each product is 33b signed. The accumulator is 35b signed. sat16 clamps to [-32768, 32767].
- Latency: motor_power and power_valid are registered exactly 5 clk edges after the edge that captured the sample. Throughput is one sample per 6 cycles.
- sample_valid while busy: stored in a 1-deep pending slot. If the slot is already full, it is overwritten with the newest angle and overrun_cnt increments, saturating at 255.
- cfg_we: writes the shadow gain only. The active gains change only at sample capture, so gain values are never mixed within one computation. cfg_sel=3 has no effect.
- clear_integ:
  - In IDLE, zeroes integ next cycle.
  - While busy, zeroes integ at OUT. The in-flight result still uses the pre-clear integ.
  - If asserted together with the ERR update, the clear wins.
- motor_power holds its value between strobes.

Decomposition:
- pid_pkg holds:
  - FSM state enum (IDLE, ERR, MAC_P, MAC_I, MAC_D, OUT)
  - cfg_sel codes
  - widths: DATA_W=16, PROD_W=33, ACC_W=35
  - the sat16 function
- One sub-module, pid_shared_mac, contains the single multiplier and the accumulator. Its inputs are a gain operand, a term operand and clr/en controls. It is combinational multiply with a registered accumulator.

Test Plan:
- After reset, angle 190 strobe: motor_power=880 (err 10, integ 10, d 10), power_valid exactly 5 edges later, busy high for 5 cycles.
- Then angle 200: motor_power=1670 (1540 + 30 + 100); then angle 0 after reset: motor_power=-15840.
- KP=0, KI=1, KD=0 written; angle 359 strobed 6 times: outputs 179, 358, 537, 716, 895, 1023 (integral clamp); clear_integ then angle 180: output 0.
- KP=1000 and angle 359 after reset: motor_power=32767 (saturation); angle 0 with KP=1000: motor_power=-32768.
- Three strobes (190, 195, 200) on consecutive cycles: 190 processed, 195 dropped, overrun_cnt=1. 200 is processed next with d=10.
- cfg_we KP=100 while busy: the in-flight result uses 77 and the next sample uses 100. Assert rst in MAC_I: no power_valid, all outputs return to reset values.
